// File: rtl/ysyx_23060203_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_rd_arbiter
// Purpose  : Round-robin arbiter sharing one AXI4 read port between N read
//            masters. A grant covers one AR handshake plus the whole R burst
//            up to rlast. Once a grant is held, address and data pass through
//            combinationally, with no buffering.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060203_rd_arbiter #(
    parameter int N = 2
) (
    input  logic            clock,
    input  logic            reset,

    input  logic [N-1:0]    s_arvalid,
    output logic [N-1:0]    s_arready,
    input  logic [N*32-1:0] s_araddr,
    input  logic [N*8-1:0]  s_arlen,
    input  logic [N*3-1:0]  s_arsize,
    output logic [N-1:0]    s_rvalid,
    input  logic [N-1:0]    s_rready,
    output logic [31:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rlast,

    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [31:0]     m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast
);

    localparam int            GW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [GW-1:0] PTR_RST = GW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] gnt;
    logic [GW-1:0] gnt_nxt;
    logic [GW-1:0] ptr;
    logic [GW-1:0] ptr_nxt;
    logic [GW-1:0] pick;
    logic          pick_vld;

    logic [31:0]   addr_arr [N];
    logic [7:0]    len_arr  [N];
    logic [2:0]    size_arr [N];

    // Split the flat per-requester AR buses into arrays indexed by requester.
    generate
        for (genvar g = 0; g < N; g++) begin : g_slice
            assign addr_arr[g] = s_araddr[g*32 +: 32];
            assign len_arr[g]  = s_arlen[g*8 +: 8];
            assign size_arr[g] = s_arsize[g*3 +: 3];
        end
    endgenerate

    // Round-robin search: first pending request starting just after ptr.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!pick_vld && s_arvalid[GW'((int'(ptr) + k) % N)]) begin
                pick_vld = 1'b1;
                pick     = GW'((int'(ptr) + k) % N);
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= PTR_RST;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic and handshake steering toward the granted requester.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_arready = '0;
        s_rvalid  = '0;
        // The address fields follow the grant at all times; only m_arvalid
        // qualifies them.
        m_araddr  = addr_arr[gnt];
        m_arlen   = len_arr[gnt];
        m_arsize  = size_arr[gnt];
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_AR;
                    gnt_nxt   = pick;
                    ptr_nxt   = pick;
                end
            end
            ST_AR: begin
                m_arvalid      = s_arvalid[gnt];
                s_arready[gnt] = m_arready;
                if (s_arvalid[gnt] && m_arready) begin
                    state_nxt = ST_R;
                end
            end
            ST_R: begin
                s_rvalid[gnt] = m_rvalid;
                m_rready      = s_rready[gnt];
                // Error responses do not end the grant; only rlast does.
                if (m_rvalid && s_rready[gnt] && m_rlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read data is broadcast; s_rvalid alone decides who consumes it.
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060203_rd_arbiter
// Purpose  : Self-checking bench for the read arbiter. The bench plays every
//            requester and the slave, and checks each cycle against an
//            ownership model: who holds the bus, and whether its AR is done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060203_rd_arbiter;

    localparam int N = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [N*32-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            m_arvalid;
    logic            m_arready = 1'b0;
    logic [31:0]     m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic            m_rvalid  = 1'b0;
    logic            m_rready;
    logic [31:0]     m_rdata   = '0;
    logic [1:0]      m_rresp   = '0;
    logic            m_rlast   = 1'b0;

    // Bench-side requester drive, packed onto the flat DUT buses.
    logic        tb_arv  [N];
    logic [31:0] tb_addr [N];
    logic [7:0]  tb_len  [N];
    logic [2:0]  tb_size [N];
    logic        tb_rr   [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_pack
            assign s_arvalid[g]         = tb_arv[g];
            assign s_araddr[g*32 +: 32] = tb_addr[g];
            assign s_arlen[g*8 +: 8]    = tb_len[g];
            assign s_arsize[g*3 +: 3]   = tb_size[g];
            assign s_rready[g]          = tb_rr[g];
        end
    endgenerate

    ysyx_23060203_rd_arbiter #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast)
    );

    // Requester transactions
    bit          rq_act   [N];
    bit          rq_acc   [N];
    logic [31:0] rq_addr  [N];
    logic [7:0]  rq_len   [N];
    logic [2:0]  rq_size  [N];
    int          rq_beats [N];
    int          p_req    [N];

    // Traffic knobs (percent probabilities, fixed length, error beat)
    int p_arready, p_rvalid, p_rready, fix_len, err_beat;
    bit rst_now;

    // Slave model
    bit          sl_busy, sl_rv;
    logic [31:0] sl_addr;
    int          sl_len, sl_beat;

    // Ownership model: owner = -1 means the bus is free
    int         owner, last;
    bit         ar_done;
    int         glog[$];
    logic [1:0] resp_log[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester with arvalid after the last winner.
    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            if (tb_arv[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input int len);
        rq_act[i]   = 1'b1;
        rq_acc[i]   = 1'b0;
        rq_addr[i]  = a;
        rq_len[i]   = 8'(len);
        rq_size[i]  = 3'($urandom_range(2));
        rq_beats[i] = 0;
    endtask

    task automatic clear_state();
        for (int i = 0; i < N; i++) begin
            rq_act[i] = 1'b0;
            rq_acc[i] = 1'b0;
        end
        sl_busy = 1'b0;
        sl_rv   = 1'b0;
        owner   = -1;
        ar_done = 1'b0;
        last    = N - 1;
    endtask

    // One clock: drive at negedge, check at negedge+1, update model at posedge.
    task automatic cycle();
        logic         e_arv, e_rr, ar_hs, r_hs;
        logic [N-1:0] e_ard, e_rv;
        logic [1:0]   obs_resp;
        @(negedge clock);
        reset = !rst_now;
        for (int i = 0; i < N; i++) begin
            if (!rq_act[i] && int'($urandom_range(99)) < p_req[i])
                issue(i, $urandom & 32'hFFFF_FFFC,
                      (fix_len >= 0) ? fix_len : int'($urandom_range(3)));
            tb_arv[i]  = rq_act[i] && !rq_acc[i];
            tb_addr[i] = rq_addr[i];
            tb_len[i]  = rq_len[i];
            tb_size[i] = rq_size[i];
            tb_rr[i]   = int'($urandom_range(99)) < p_rready;
        end
        m_arready = int'($urandom_range(99)) < p_arready;
        if (sl_busy) begin
            m_rvalid = sl_rv || (int'($urandom_range(99)) < p_rvalid);
            sl_rv    = m_rvalid;
        end else begin
            m_rvalid = 1'b0;
        end
        m_rdata = sl_addr + 32'(sl_beat);
        m_rlast = sl_busy && (sl_beat == sl_len);
        if (err_beat == -2) m_rresp = sl_addr[5:4] ^ 2'(sl_beat);
        else                m_rresp = (sl_beat == err_beat) ? 2'b10 : 2'b00;
        #1;
        e_arv = 1'b0;
        e_rr  = 1'b0;
        e_ard = '0;
        e_rv  = '0;
        for (int i = 0; i < N; i++) begin
            if (i == owner) begin
                if (!ar_done) begin
                    e_arv = tb_arv[i];
                    e_ard = e_ard | (N'(m_arready) << i);
                end else begin
                    e_rv = e_rv | (N'(m_rvalid) << i);
                    e_rr = tb_rr[i];
                end
            end
        end
        chk("m_arvalid", 32'(m_arvalid), 32'(e_arv));
        if (e_arv) begin
            chk("m_araddr", m_araddr, rq_addr[owner]);
            chk("m_arlen", 32'(m_arlen), 32'(rq_len[owner]));
            chk("m_arsize", 32'(m_arsize), 32'(rq_size[owner]));
        end
        chk("s_arready", 32'(s_arready), 32'(e_ard));
        chk("s_rvalid", 32'(s_rvalid), 32'(e_rv));
        chk("m_rready", 32'(m_rready), 32'(e_rr));
        chk("s_rdata", s_rdata, m_rdata);
        chk("s_rresp", 32'(s_rresp), 32'(m_rresp));
        chk("s_rlast", 32'(s_rlast), 32'(m_rlast));
        obs_resp = s_rresp;
        ar_hs = e_arv && m_arready;
        r_hs  = e_rr && m_rvalid;
        @(posedge clock);
        if (!reset) begin
            clear_state();
        end else if (owner < 0) begin
            owner = rr_pick();
            if (owner >= 0) begin
                last    = owner;
                ar_done = 1'b0;
                glog.push_back(owner);
            end
        end else if (!ar_done) begin
            if (ar_hs) begin
                ar_done       = 1'b1;
                rq_acc[owner] = 1'b1;
                sl_busy       = 1'b1;
                sl_rv         = 1'b0;
                sl_addr       = rq_addr[owner];
                sl_len        = int'(rq_len[owner]);
                sl_beat       = 0;
            end
        end else if (r_hs) begin
            rq_beats[owner]++;
            resp_log.push_back(obs_resp);
            sl_rv = 1'b0;
            if (m_rlast) begin
                chk("beat_count", rq_beats[owner], 32'(rq_len[owner]) + 1);
                rq_act[owner] = 1'b0;
                owner         = -1;
                ar_done       = 1'b0;
                sl_busy       = 1'b0;
            end else begin
                sl_beat++;
            end
        end
    endtask

    task automatic do_reset();
        rst_now = 1'b1;
        cycle();
        rst_now = 1'b0;
        glog.delete();
        resp_log.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            tb_arv[i] = 1'b0; tb_addr[i] = '0; tb_len[i] = '0;
            tb_size[i] = '0; tb_rr[i] = 1'b0; p_req[i] = 0;
            rq_addr[i] = '0; rq_len[i] = '0; rq_size[i] = '0; rq_beats[i] = 0;
        end
        p_arready = 100; p_rvalid = 100; p_rready = 100;
        fix_len = -1; err_beat = -1; rst_now = 1'b0;
        sl_addr = '0; sl_len = 0; sl_beat = 0;
        clear_state();
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);

        // Single requester 1, 4-beat burst
        issue(1, 32'h8000_0010, 3);
        repeat (8) cycle();
        chk("t1_grants", glog.size(), 1);
        if (glog.size() > 0) chk("t1_winner", glog[0], 1);
        chk("t1_done", 32'(rq_act[1]), 0);
        chk("t1_beats", rq_beats[1], 4);

        // Tie after reset: 0 first, then alternate
        do_reset();
        p_req[0] = 100; p_req[1] = 100; fix_len = 1;
        repeat (20) cycle();
        chk("t2_count", 32'(glog.size() >= 4), 1);
        if (glog.size() >= 4) begin
            chk("t2_g0", glog[0], 0);
            chk("t2_g1", glog[1], 1);
            chk("t2_g2", glog[2], 0);
            chk("t2_g3", glog[3], 1);
        end

        // Late requester 1 wins the very next grant
        do_reset();
        p_req[0] = 100; p_req[1] = 0; fix_len = 3;
        repeat (4) cycle();
        issue(1, 32'h1234_5670, 3);
        repeat (14) cycle();
        chk("t3_count", 32'(glog.size() >= 2), 1);
        if (glog.size() >= 2) begin
            chk("t3_g0", glog[0], 0);
            chk("t3_g1", glog[1], 1);
        end

        // Back-pressure on AR and R
        do_reset();
        p_req[0] = 0; p_req[1] = 0;
        issue(0, 32'h8000_0100, 3);
        p_arready = 0;
        repeat (6) cycle();
        chk("t4_no_grant_yet", 32'(rq_acc[0]), 0);
        p_arready = 100; p_rvalid = 50; p_rready = 50;
        for (int k = 0; k < 200 && rq_act[0]; k++) cycle();
        chk("t4_done", 32'(rq_act[0]), 0);
        chk("t4_beats", rq_beats[0], 4);
        p_rvalid = 100; p_rready = 100;

        // SLVERR on beat 1 does not end the grant
        do_reset();
        err_beat = 1;
        issue(1, 32'h8000_0200, 3);
        repeat (10) cycle();
        chk("t5_nresp", resp_log.size(), 4);
        if (resp_log.size() == 4) begin
            chk("t5_resp0", 32'(resp_log[0]), 0);
            chk("t5_resp1", 32'(resp_log[1]), 2);
            chk("t5_resp3", 32'(resp_log[3]), 0);
        end
        chk("t5_grants", glog.size(), 1);
        err_beat = -1;

        // Reset during beat 2, then normal arbitration from ptr = N-1
        do_reset();
        issue(0, 32'h8000_0300, 3);
        for (int k = 0; k < 20 && rq_beats[0] < 2; k++) cycle();
        chk("t6_reached_beat2", rq_beats[0], 2);
        do_reset();
        cycle();
        chk("t6_arvalid0", 32'(m_arvalid), 0);
        chk("t6_rready0", 32'(m_rready), 0);
        issue(1, 32'h8000_0400, 1);
        issue(0, 32'h8000_0500, 1);
        repeat (12) cycle();
        chk("t6_count", 32'(glog.size() >= 2), 1);
        if (glog.size() >= 2) begin
            chk("t6_g0", glog[0], 0);
            chk("t6_g1", glog[1], 1);
        end

        // Randomised traffic
        do_reset();
        p_req[0] = 35; p_req[1] = 35;
        p_arready = 60; p_rvalid = 60; p_rready = 60;
        fix_len = -1; err_beat = -2;
        repeat (3000) cycle();
        chk("t7_activity", 32'(glog.size() > 50), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
